// File: rtl/exe_stage_pkg.sv
// Shared ALU operation codes for the decode and execute stages.
package exe_stage_pkg;

  localparam int ALU_OP_W = 6;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 6'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 6'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 6'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 6'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 6'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR    = 6'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 6'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 6'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 6'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 6'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 6'd10;
  localparam logic [ALU_OP_W-1:0] ALU_SLLV   = 6'd11;
  localparam logic [ALU_OP_W-1:0] ALU_SRLV   = 6'd12;
  localparam logic [ALU_OP_W-1:0] ALU_SRAV   = 6'd13;
  localparam logic [ALU_OP_W-1:0] ALU_LUI    = 6'd14;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_A = 6'd15;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 6'd16;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational 32-bit ALU; variable shifts take their amount from A[4:0].
import exe_stage_pkg::*;

module exe_alu (
  input  logic [31:0]         i_a,
  input  logic [31:0]         i_b,
  input  logic [4:0]          i_shamt,
  input  logic [ALU_OP_W-1:0] i_op,
  output logic [31:0]         o_result
);

  logic [4:0] w_vshamt;
  assign w_vshamt = i_a[4:0];

  always_comb begin
    o_result = 32'd0;
    case (i_op)
      ALU_ADD:    o_result = i_a + i_b;
      ALU_SUB:    o_result = i_a - i_b;
      ALU_AND:    o_result = i_a & i_b;
      ALU_OR:     o_result = i_a | i_b;
      ALU_XOR:    o_result = i_a ^ i_b;
      ALU_NOR:    o_result = ~(i_a | i_b);
      ALU_SLT:    o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:   o_result = {31'd0, (i_a < i_b)};
      ALU_SLL:    o_result = i_b << i_shamt;
      ALU_SRL:    o_result = i_b >> i_shamt;
      ALU_SRA:    o_result = $unsigned($signed(i_b) >>> i_shamt);
      ALU_SLLV:   o_result = i_b << w_vshamt;
      ALU_SRLV:   o_result = i_b >> w_vshamt;
      ALU_SRAV:   o_result = $unsigned($signed(i_b) >>> w_vshamt);
      ALU_LUI:    o_result = {i_b[15:0], 16'd0};
      ALU_PASS_A: o_result = i_a;
      ALU_PASS_B: o_result = i_b;
      default:    o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: MEM->EXE operand bypass, ALU, and a one-cycle register into MEM.
import exe_stage_pkg::*;

module exe_stage #(
  parameter bit HAS_FORWARDING = 1'b1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         Instr1_IN,
  input  logic [31:0]         Instr1_PC_IN,
  input  logic                Request_Alt_PC,
  input  logic [31:0]         Alt_PC,
  input  logic [4:0]          RegisterA1_IN,
  input  logic [4:0]          RegisterB1_IN,
  input  logic [31:0]         OperandA1_IN,
  input  logic [31:0]         OperandB1_IN,
  input  logic [4:0]          WriteRegister1_IN,
  input  logic [31:0]         MemWriteData1_IN,
  input  logic                RegWrite1_IN,
  input  logic                MemRead1_IN,
  input  logic                MemWrite1_IN,
  input  logic [ALU_OP_W-1:0] ALU_Control1_IN,
  input  logic [4:0]          ShiftAmount1_IN,
  input  logic [4:0]          BypassReg1_MEMEXE,
  input  logic [31:0]         BypassData1_MEMEXE,
  input  logic                BypassValid1_MEMEXE,
  output logic [31:0]         Instr1_OUT,
  output logic [31:0]         Instr1_PC_OUT,
  output logic [31:0]         ALU_result1_OUT,
  output logic [31:0]         MemWriteData1_OUT,
  output logic [4:0]          WriteRegister1_OUT,
  output logic                RegWrite1_OUT,
  output logic                MemRead1_OUT,
  output logic                MemWrite1_OUT,
  output logic [ALU_OP_W-1:0] ALU_Control1_OUT,
  output logic [31:0]         Alt_PC1,
  output logic                Request_Alt_PC1,
  output logic [31:0]         ALU_result_async1,
  output logic                ALU_result_async_valid1
);

  logic        w_hit_a;
  logic        w_hit_b;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [31:0] w_store_data;
  logic [31:0] w_result;

  // Register 0 is hardwired zero, so a bypass targeting it must never win.
  assign w_hit_a = HAS_FORWARDING && BypassValid1_MEMEXE &&
                   (BypassReg1_MEMEXE == RegisterA1_IN) && (RegisterA1_IN != 5'd0);
  assign w_hit_b = HAS_FORWARDING && BypassValid1_MEMEXE &&
                   (BypassReg1_MEMEXE == RegisterB1_IN) && (RegisterB1_IN != 5'd0);

  assign w_op_a       = w_hit_a ? BypassData1_MEMEXE : OperandA1_IN;
  assign w_op_b       = w_hit_b ? BypassData1_MEMEXE : OperandB1_IN;
  assign w_store_data = (MemWrite1_IN && w_hit_b) ? BypassData1_MEMEXE : MemWriteData1_IN;

  exe_alu u_alu (
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .i_shamt  (ShiftAmount1_IN),
    .i_op     (ALU_Control1_IN),
    .o_result (w_result)
  );

  // Loads produce their value in MEM, so an EXE result is only usable for non-loads.
  assign ALU_result_async1       = w_result;
  assign ALU_result_async_valid1 = HAS_FORWARDING && RegWrite1_IN && !MemRead1_IN;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Instr1_OUT         <= 32'd0;
      Instr1_PC_OUT      <= 32'd0;
      ALU_result1_OUT    <= 32'd0;
      MemWriteData1_OUT  <= 32'd0;
      WriteRegister1_OUT <= 5'd0;
      RegWrite1_OUT      <= 1'b0;
      MemRead1_OUT       <= 1'b0;
      MemWrite1_OUT      <= 1'b0;
      ALU_Control1_OUT   <= '0;
      Alt_PC1            <= 32'd0;
      Request_Alt_PC1    <= 1'b0;
    end else begin
      Instr1_OUT         <= Instr1_IN;
      Instr1_PC_OUT      <= Instr1_PC_IN;
      ALU_result1_OUT    <= w_result;
      MemWriteData1_OUT  <= w_store_data;
      WriteRegister1_OUT <= WriteRegister1_IN;
      RegWrite1_OUT      <= RegWrite1_IN;
      MemRead1_OUT       <= MemRead1_IN;
      MemWrite1_OUT      <= MemWrite1_IN;
      ALU_Control1_OUT   <= ALU_Control1_IN;
      Alt_PC1            <= Alt_PC;
      Request_Alt_PC1    <= Request_Alt_PC;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with a behavioural model checked every cycle.
module tb_exe_stage;

  logic        CLK, RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, Alt_PC, OperandA1_IN, OperandB1_IN;
  logic [31:0] MemWriteData1_IN, BypassData1_MEMEXE;
  logic        Request_Alt_PC, RegWrite1_IN, MemRead1_IN, MemWrite1_IN, BypassValid1_MEMEXE;
  logic [4:0]  RegisterA1_IN, RegisterB1_IN, WriteRegister1_IN, ShiftAmount1_IN, BypassReg1_MEMEXE;
  logic [5:0]  ALU_Control1_IN;

  logic [31:0] Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT, Alt_PC1, ALU_result_async1;
  logic [4:0]  WriteRegister1_OUT;
  logic        RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT, Request_Alt_PC1, ALU_result_async_valid1;
  logic [5:0]  ALU_Control1_OUT;

  int n_vec = 0;
  int n_bad = 0;

  exe_stage #(.HAS_FORWARDING(1'b1)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC),
    .RegisterA1_IN(RegisterA1_IN), .RegisterB1_IN(RegisterB1_IN),
    .OperandA1_IN(OperandA1_IN), .OperandB1_IN(OperandB1_IN),
    .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
    .RegWrite1_IN(RegWrite1_IN), .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .ShiftAmount1_IN(ShiftAmount1_IN),
    .BypassReg1_MEMEXE(BypassReg1_MEMEXE), .BypassData1_MEMEXE(BypassData1_MEMEXE),
    .BypassValid1_MEMEXE(BypassValid1_MEMEXE),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .ALU_result1_OUT(ALU_result1_OUT), .MemWriteData1_OUT(MemWriteData1_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
    .MemRead1_OUT(MemRead1_OUT), .MemWrite1_OUT(MemWrite1_OUT),
    .ALU_Control1_OUT(ALU_Control1_OUT), .Alt_PC1(Alt_PC1), .Request_Alt_PC1(Request_Alt_PC1),
    .ALU_result_async1(ALU_result_async1), .ALU_result_async_valid1(ALU_result_async_valid1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] v);
    if (BypassValid1_MEMEXE && r != 0 && BypassReg1_MEMEXE == r) return BypassData1_MEMEXE;
    return v;
  endfunction

  function automatic logic [31:0] model_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] b, input int sh);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (sa < sb) ? 32'd1 : 32'd0;
      7:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      8:  return b * (32'd1 << sh);
      9:  return b / (33'd1 << sh);
      10: return 32'(sb >>> sh);
      11: return model_alu(8,  a, b, int'(a % 32));
      12: return model_alu(9,  a, b, int'(a % 32));
      13: return model_alu(10, a, b, int'(a % 32));
      14: return b * 32'd65536;
      15: return a;
      16: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    return model_alu(int'(ALU_Control1_IN), pick(RegisterA1_IN, OperandA1_IN),
                     pick(RegisterB1_IN, OperandB1_IN), int'(ShiftAmount1_IN));
  endfunction

  function automatic logic [174:0] model_regs();
    logic [31:0] sd;
    sd = MemWrite1_IN ? pick(RegisterB1_IN, MemWriteData1_IN) : MemWriteData1_IN;
    if (MemWrite1_IN && !(BypassValid1_MEMEXE && RegisterB1_IN != 0 && BypassReg1_MEMEXE == RegisterB1_IN))
      sd = MemWriteData1_IN;
    return {Instr1_IN, Instr1_PC_IN, model_result(), sd, WriteRegister1_IN,
            RegWrite1_IN, MemRead1_IN, MemWrite1_IN, ALU_Control1_IN, Alt_PC, Request_Alt_PC};
  endfunction

  logic [174:0] exp_regs;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) exp_regs <= '0;
    else       exp_regs <= model_regs();
  end

  wire [174:0] dut_regs = {Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT,
                           WriteRegister1_OUT, RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT,
                           ALU_Control1_OUT, Alt_PC1, Request_Alt_PC1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end else
      $display("ok   %s: %08h", name, act);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    if (!RESET) begin
      n_vec++;
      if (dut_regs !== exp_regs || ALU_result_async1 !== model_result() ||
          ALU_result_async_valid1 !== (RegWrite1_IN & ~MemRead1_IN)) begin
        n_bad++;
        $display("FAIL model t=%0t: regs %h async %08h/%b expected regs %h async %08h/%b",
                 $time, dut_regs, ALU_result_async1, ALU_result_async_valid1,
                 exp_regs, model_result(), RegWrite1_IN & ~MemRead1_IN);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_in();
    Instr1_IN = 32'h0; Instr1_PC_IN = 32'h0; Alt_PC = 32'h0; Request_Alt_PC = 1'b0;
    RegisterA1_IN = 5'd0; RegisterB1_IN = 5'd0; OperandA1_IN = 32'd0; OperandB1_IN = 32'd0;
    WriteRegister1_IN = 5'd0; MemWriteData1_IN = 32'd0;
    RegWrite1_IN = 1'b0; MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
    ALU_Control1_IN = 6'd0; ShiftAmount1_IN = 5'd0;
    BypassReg1_MEMEXE = 5'd0; BypassData1_MEMEXE = 32'd0; BypassValid1_MEMEXE = 1'b0;
  endtask

  // Inputs are set just after a rising edge; the async result is checked at the
  // falling edge and the registered result just after the following rising edge.
  task automatic step(input string name, input logic [31:0] exp_res);
    @(negedge CLK);
    chk({name, "_async"}, ALU_result_async1, exp_res);
    @(posedge CLK); #1;
    chk({name, "_reg"}, ALU_result1_OUT, exp_res);
  endtask

  initial begin
    clear_in();
    RESET = 1'b1;
    #7;
    chk("reset_result", ALU_result1_OUT, 32'd0);
    chk("reset_altreq", {31'd0, Request_Alt_PC1}, 32'd0);
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;

    Instr1_IN = 32'h0085_0020; Instr1_PC_IN = 32'h100; WriteRegister1_IN = 5'd9;
    RegWrite1_IN = 1'b1; OperandA1_IN = 32'd5; OperandB1_IN = 32'd7; ALU_Control1_IN = 6'd0;
    @(negedge CLK);
    chk("add_valid", {31'd0, ALU_result_async_valid1}, 32'd1);
    @(posedge CLK); #1;
    chk("add_pc", Instr1_PC_OUT, 32'h100);
    chk("add_reg", ALU_result1_OUT, 32'd12);

    OperandA1_IN = 32'hFFFF_FFFF; OperandB1_IN = 32'd1;
    ALU_Control1_IN = 6'd6;  step("slt", 32'd1);
    ALU_Control1_IN = 6'd7;  step("sltu", 32'd0);

    OperandB1_IN = 32'h8000_0000; ShiftAmount1_IN = 5'd4;
    ALU_Control1_IN = 6'd10; step("sra", 32'hF800_0000);
    ALU_Control1_IN = 6'd9;  step("srl", 32'h0800_0000);
    OperandA1_IN = 32'h0000_0021;  // variable shift uses A[4:0] = 1
    ALU_Control1_IN = 6'd13; step("srav", 32'hC000_0000);
    ALU_Control1_IN = 6'd14; OperandB1_IN = 32'h0000_1234; step("lui", 32'h1234_0000);
    ALU_Control1_IN = 6'd5;  OperandA1_IN = 32'h0F0F_0000; OperandB1_IN = 32'h0000_00FF;
    step("nor", 32'hF0F0_FF00);
    ALU_Control1_IN = 6'd1;  OperandA1_IN = 32'd3; OperandB1_IN = 32'd5; step("sub", 32'hFFFF_FFFE);
    ALU_Control1_IN = 6'd40; step("undef_op", 32'd0);

    ALU_Control1_IN = 6'd0; RegisterA1_IN = 5'd3; OperandA1_IN = 32'd1; OperandB1_IN = 32'd1;
    BypassReg1_MEMEXE = 5'd3; BypassData1_MEMEXE = 32'd100; BypassValid1_MEMEXE = 1'b1;
    step("fwd_a", 32'd101);
    RegisterA1_IN = 5'd0; BypassReg1_MEMEXE = 5'd0; step("fwd_r0", 32'd2);
    RegisterA1_IN = 5'd3; BypassReg1_MEMEXE = 5'd3; BypassValid1_MEMEXE = 1'b0;
    step("fwd_novalid", 32'd2);

    clear_in();
    MemWrite1_IN = 1'b1; RegisterB1_IN = 5'd4; MemWriteData1_IN = 32'h1111;
    OperandA1_IN = 32'h1000; OperandB1_IN = 32'h8; ALU_Control1_IN = 6'd0;
    BypassReg1_MEMEXE = 5'd4; BypassData1_MEMEXE = 32'hDEAD; BypassValid1_MEMEXE = 1'b1;
    step("store_addr", 32'h0000_EEAD);
    chk("store_data", MemWriteData1_OUT, 32'hDEAD);
    MemWrite1_IN = 1'b0; step("nostore_addr", 32'h0000_EEAD);
    chk("nostore_data", MemWriteData1_OUT, 32'h1111);

    clear_in();
    RegWrite1_IN = 1'b1; MemRead1_IN = 1'b1;
    @(negedge CLK);
    chk("load_valid", {31'd0, ALU_result_async_valid1}, 32'd0);

    for (int op = 0; op < 18; op++) begin
      @(posedge CLK); #1;
      ALU_Control1_IN = 6'(op); OperandA1_IN = 32'h8765_4323 + 32'(op);
      OperandB1_IN = 32'hF00D_1357 ^ 32'(op * 77); ShiftAmount1_IN = 5'(op + 3);
      RegWrite1_IN = op[0]; MemRead1_IN = op[1]; Instr1_IN = 32'(op * 1000);
    end

    @(posedge CLK); #1;
    Request_Alt_PC = 1'b1; Alt_PC = 32'h4000_0000; RegWrite1_IN = 1'b1; MemWrite1_IN = 1'b1;
    @(posedge CLK); #1;
    chk("altreq_pre", {31'd0, Request_Alt_PC1}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_altreq", {31'd0, Request_Alt_PC1}, 32'd0);
    chk("rst_altpc", Alt_PC1, 32'd0);
    chk("rst_result", ALU_result1_OUT, 32'd0);
    chk("rst_ctrl", {29'd0, RegWrite1_OUT, MemRead1_OUT, MemWrite1_OUT}, 32'd0);
    @(negedge CLK); #2 RESET = 1'b0;
    clear_in();
    OperandA1_IN = 32'd20; OperandB1_IN = 32'd22; @(posedge CLK); #1;
    chk("post_reset", ALU_result1_OUT, 32'd42);
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
